// File: rtl/pio_out_pulse_if.sv
// Avalon-MM slave bus bundle for pio_out_pulse: 3-bit word address, 32-bit data,
// active-low strobes.
interface pio_out_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, read_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, read_n, writedata, output readdata);
endinterface

// File: rtl/pio_out_pulse.sv
// Avalon-MM output PIO with set/clear aliases and a hardware one-shot pulse engine.
// Optional interrupt output and IRQMASK register enabled by `define PIO_OUT_PULSE_IRQ_EN.
module pio_out_pulse #(
    parameter int               WIDTH       = 8,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    pio_out_pulse_if.slave   bus,
    output logic [WIDTH-1:0] out_port,
`ifdef PIO_OUT_PULSE_IRQ_EN
    output logic             irq,
`endif
    output logic             busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLR    = 3'd2;
    localparam logic [2:0] A_PLEN   = 3'd3;
    localparam logic [2:0] A_PULSE  = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
`ifdef PIO_OUT_PULSE_IRQ_EN
    localparam logic [2:0] A_IRQM   = 3'd6;
`endif

    state_t           state;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] pmask;
    logic [CNT_W-1:0] plen;
    logic [CNT_W-1:0] cnt;
    logic             overrun;
    logic             done;

    logic             wr_en, rd_en;
    logic [WIDTH-1:0] wd_w;
    logic [CNT_W-1:0] wd_c;
    logic             pulse_wr, pulse_go, pulse_ovr, done_set;
    logic             unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign rd_en     = bus.chipselect & ~bus.read_n;
    assign wd_w      = bus.writedata[WIDTH-1:0];
    assign wd_c      = bus.writedata[CNT_W-1:0];
    assign unused_wd = ^bus.writedata;

    // Zero-mask PULSE writes are no-ops in every state, so they never raise overrun.
    assign pulse_wr  = wr_en && (bus.address == A_PULSE) && (|wd_w);
    assign pulse_go  = pulse_wr && (state == IDLE);
    assign pulse_ovr = pulse_wr && (state == ACTIVE);
    assign done_set  = (state == ACTIVE) && (cnt == CNT_W'(1));

    assign busy      = (state == ACTIVE);
    assign out_port  = busy ? (data ^ pmask) : data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data    <= RESET_VALUE;
            pmask   <= '0;
            plen    <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.address)
                    A_DATA:  data <= wd_w;
                    A_SET:   data <= data | wd_w;
                    A_CLR:   data <= data & ~wd_w;
                    A_PLEN:  plen <= wd_c;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (pulse_go) begin
                        pmask <= wd_w;
                        cnt   <= (plen == '0) ? CNT_W'(1) : plen;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Clear first so a hardware set in the same cycle takes priority.
            if (wr_en && bus.address == A_STATUS) begin
                if (bus.writedata[1]) overrun <= 1'b0;
                if (bus.writedata[2]) done    <= 1'b0;
            end
            if (pulse_ovr) overrun <= 1'b1;
            if (done_set)  done    <= 1'b1;
        end
    end

`ifdef PIO_OUT_PULSE_IRQ_EN
    logic [1:0] irqmask;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr_en && bus.address == A_IRQM) irqmask <= bus.writedata[1:0];
            irq <= (done & irqmask[0]) | (overrun & irqmask[1]);
        end
    end
`endif

    always_comb begin
        bus.readdata = '0;
        if (rd_en) begin
            case (bus.address)
                A_DATA, A_SET, A_CLR: bus.readdata[WIDTH-1:0] = data;
                A_PLEN:               bus.readdata[CNT_W-1:0] = plen;
                A_PULSE:              bus.readdata[WIDTH-1:0] = pmask;
                A_STATUS:             bus.readdata[2:0]       = {done, overrun, busy};
`ifdef PIO_OUT_PULSE_IRQ_EN
                A_IRQM:               bus.readdata[1:0]       = irqmask;
`endif
                default:              bus.readdata = '0;
            endcase
        end
    end
endmodule
